mem_wb: RTL



---
 rtl/mem_wb.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb.sv
// mem_wb: memory-access / write-back stage of the RV32I pipeline.
// Non-memory ops pass their ALU result straight to write-back one cycle later.
// Loads and stores are issued on a req/ack data bus. Execute is stalled until
// the access completes, or until the optional ack timeout aborts it.
module mem_wb #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode_exe_2_mem_i,
    input  logic [4:0]  rd_exe_2_mem_i,
    input  logic [31:0] result_exe_2_mem_i,
    input  logic [31:0] store_data_exe_2_mem_i,
    output logic        stall_mem_o,
    output logic [4:0]  rd_mem_2_dec_o,
    output logic [31:0] rd_data_mem_2_dec_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (ACK_TIMEOUT > 0);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    // Details of the outstanding load, kept for data extraction at ack time.
    logic [4:0]        ld_rd, ld_rd_nx;
    logic [2:0]        ld_f3, ld_f3_nx;
    logic [1:0]        ld_off, ld_off_nx;

    logic [4:0]        rd_nx;
    logic [31:0]       rd_data_nx;
    logic              req_nx;
    logic              we_nx;
    logic [31:0]       addr_nx;
    logic [3:0]        be_nx;
    logic [31:0]       wdata_nx;
    logic              misalign_nx;
    logic              bus_err_nx;

    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              is_load;
    logic              is_store;
    logic              is_bubble;
    logic              f3_legal;
    logic              aligned;
    logic [3:0]        be_dec;
    logic [31:0]       wdata_dec;
    logic [31:0]       load_value;
    logic              timeout_hit;

    // Pick the addressed lane out of the returned word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign stall_mem_o = (state == WAIT_ACK);
    assign load_value  = extract_load(dmem_rdata_i, ld_f3, ld_off);
    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

    // Decode the incoming op: class, funct3 legality, alignment, lanes and store data.
    always_comb begin
        op        = opcode_exe_2_mem_i[6:0];
        funct3    = opcode_exe_2_mem_i[9:7];
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_bubble = (opcode_exe_2_mem_i == '0);
        f3_legal  = 1'b0;
        aligned   = 1'b1;
        be_dec    = 4'b1111;
        wdata_dec = store_data_exe_2_mem_i;

        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end

        case (funct3[1:0])
            2'b00: begin
                aligned   = 1'b1;
                be_dec    = 4'b0001 << result_exe_2_mem_i[1:0];
                wdata_dec = {4{store_data_exe_2_mem_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~result_exe_2_mem_i[0];
                be_dec    = result_exe_2_mem_i[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{store_data_exe_2_mem_i[15:0]}};
            end
            default: begin
                aligned   = (result_exe_2_mem_i[1:0] == 2'b00);
                be_dec    = 4'b1111;
                wdata_dec = store_data_exe_2_mem_i;
            end
        endcase
    end

    // Next-state and next-output logic; write-back and pulses default to zero every cycle.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ld_rd_nx    = ld_rd;
        ld_f3_nx    = ld_f3;
        ld_off_nx   = ld_off;
        req_nx      = dmem_req_o;
        we_nx       = dmem_we_o;
        addr_nx     = dmem_addr_o;
        be_nx       = dmem_be_o;
        wdata_nx    = dmem_wdata_o;
        rd_nx       = 5'd0;
        rd_data_nx  = 32'd0;
        misalign_nx = 1'b0;
        bus_err_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (is_load || is_store) begin
                    if (f3_legal && aligned) begin
                        req_nx    = 1'b1;
                        we_nx     = is_store;
                        addr_nx   = {result_exe_2_mem_i[31:2], 2'b00};
                        be_nx     = be_dec;
                        wdata_nx  = is_store ? wdata_dec : 32'd0;
                        ld_rd_nx  = is_load ? rd_exe_2_mem_i : 5'd0;
                        ld_f3_nx  = funct3;
                        ld_off_nx = result_exe_2_mem_i[1:0];
                        cnt_nx    = '0;
                        state_nx  = WAIT_ACK;
                    end else if (f3_legal) begin
                        misalign_nx = 1'b1;
                    end
                end else if (!is_bubble && rd_exe_2_mem_i != 5'd0) begin
                    rd_nx      = rd_exe_2_mem_i;
                    rd_data_nx = result_exe_2_mem_i;
                end
            end

            WAIT_ACK: begin
                if (dmem_ack_i || timeout_hit) begin
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    addr_nx  = 32'd0;
                    be_nx    = 4'd0;
                    wdata_nx = 32'd0;
                    state_nx = IDLE;
                    if (dmem_ack_i) begin
                        if (!dmem_we_o && ld_rd != 5'd0) begin
                            rd_nx      = ld_rd;
                            rd_data_nx = load_value;
                        end
                    end else begin
                        bus_err_nx = 1'b1;
                    end
                end else if (TIMEOUT_EN) begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything and drops any pending access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            ld_rd               <= 5'd0;
            ld_f3               <= 3'd0;
            ld_off              <= 2'd0;
            rd_mem_2_dec_o      <= 5'd0;
            rd_data_mem_2_dec_o <= 32'd0;
            dmem_req_o          <= 1'b0;
            dmem_we_o           <= 1'b0;
            dmem_addr_o         <= 32'd0;
            dmem_be_o           <= 4'd0;
            dmem_wdata_o        <= 32'd0;
            misalign_o          <= 1'b0;
            bus_err_o           <= 1'b0;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            ld_rd               <= ld_rd_nx;
            ld_f3               <= ld_f3_nx;
            ld_off              <= ld_off_nx;
            rd_mem_2_dec_o      <= rd_nx;
            rd_data_mem_2_dec_o <= rd_data_nx;
            dmem_req_o          <= req_nx;
            dmem_we_o           <= we_nx;
            dmem_addr_o         <= addr_nx;
            dmem_be_o           <= be_nx;
            dmem_wdata_o        <= wdata_nx;
            misalign_o          <= misalign_nx;
            bus_err_o           <= bus_err_nx;
        end
    end

endmodule
